ex_muldiv_ctrl: RTL and testbench

//  Multi-cycle sequencer for RV32M multiply/divide in the EX stage. Accepts an M-op when
//  EX holds one, stalls IF/ID/EX while its iterative shift-add / restoring-divide datapath

---
 rtl/ex_muldiv_ctrl_if.sv | 25 ++
 rtl/ex_muldiv_ctrl.sv | 143 ++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage handshake between the pipeline and the RV32M multi-cycle sequencer.
// The master drives the EX-stage operands; the slave returns stall and result.
interface ex_muldiv_ctrl_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic            ex_is_muldiv;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic            ex_flush;
    logic            md_stall;
    logic            md_valid;
    logic [XLEN-1:0] md_result;

    modport master (
        output ex_valid, ex_is_muldiv, ex_funct3, ex_rs1, ex_rs2, ex_flush,
        input  md_stall, md_valid, md_result
    );

    modport slave (
        input  ex_valid, ex_is_muldiv, ex_funct3, ex_rs1, ex_rs2, ex_flush,
        output md_stall, md_valid, md_result
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide sequencer: stalls IF/ID/EX while an XLEN-step shift-add
// multiply or restoring divide runs on operand magnitudes, then pulses the result.
module ex_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_ctrl_if.slave   bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    logic              start, is_div, sgn_a, sgn_b, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_acc, prod;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem, div_quo, quo_s, rem_s;

    assign start  = bus.ex_valid & bus.ex_is_muldiv & ~bus.ex_flush & (state_q == S_IDLE);
    assign is_div = bus.ex_funct3[2];
    assign sgn_a  = is_div ? ~bus.ex_funct3[0] : (bus.ex_funct3[1:0] != 2'b11);
    assign sgn_b  = is_div ? ~bus.ex_funct3[0] : ~bus.ex_funct3[1];
    assign sa     = sgn_a & bus.ex_rs1[XLEN-1];
    assign sb     = sgn_b & bus.ex_rs2[XLEN-1];
    assign mag_a  = sa ? -bus.ex_rs1 : bus.ex_rs1;
    assign mag_b  = sb ? -bus.ex_rs2 : bus.ex_rs2;

    // Multiply: multiplier sits in acc low half and is consumed LSB-first while
    // partial sums enter the high half, so the full product ends up in acc.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: partial remainder in acc low half, dividend shifts out of a_q as
    // quotient bits shift in; diff MSB is the borrow of the trial subtract.
    assign div_sh   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_ge   = ~div_diff[XLEN];
    assign div_rem  = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    assign div_quo  = {a_q[XLEN-2:0], div_ge};

    assign prod  = neg_q ? -mul_acc : mul_acc;
    assign quo_s = neg_q ? -div_quo : div_quo;
    assign rem_s = neg_q ? -div_rem : div_rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d  = bus.ex_funct3;
                    neg_d = (is_div & bus.ex_funct3[1]) ? sa : (sa ^ sb);
                    a_d   = mag_a;
                    b_d   = mag_b;
                    cnt_d = CW'(XLEN-1);
                    if (is_div && bus.ex_rs2 == '0) begin
                        res_d   = bus.ex_funct3[1] ? bus.ex_rs1 : '1;
                        state_d = S_DONE;
                    end else if (is_div && !bus.ex_funct3[0] && bus.ex_rs1 == XMIN && bus.ex_rs2 == '1) begin
                        res_d   = bus.ex_funct3[1] ? '0 : XMIN;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = is_div ? '0 : {{XLEN{1'b0}}, mag_b};
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (f3_q[2]) begin
                    acc_d = {{XLEN{1'b0}}, div_rem};
                    a_d   = div_quo;
                end else begin
                    acc_d = mul_acc;
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    case (f3_q)
                        3'b000:          res_d = prod[XLEN-1:0];
                        3'b100, 3'b101:  res_d = quo_s;
                        3'b110, 3'b111:  res_d = rem_s;
                        default:         res_d = prod[2*XLEN-1:XLEN];
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus.ex_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            f3_d    = '0;
            neg_d   = 1'b0;
            a_d     = '0;
            b_d     = '0;
            acc_d   = '0;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign bus.md_stall  = start | (state_q == S_BUSY);
    assign bus.md_valid  = (state_q == S_DONE) & ~bus.ex_flush;
    assign bus.md_result = res_q;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: stimulus pushes expected results into a
// scoreboard queue that an independent negedge monitor drains on md_valid.
module tb_ex_muldiv_ctrl;
    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    ex_muldiv_ctrl_if #(.XLEN(32)) bus ();

    ex_muldiv_ctrl #(.XLEN(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.md_valid === 1'b1) begin
                if (prev) check("valid_pulse_width", 32'd2, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", bus.md_result, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, bus.md_result, e.val);
                end
            end
            prev = (bus.md_valid === 1'b1);
        end
    endtask

    // Issue one op at the next negedge, hold ex_valid for the accept cycle only,
    // count stalled cycles until md_valid, and leave the bench in the DONE cycle.
    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int exp_stall);
        int   stalls;
        int   cyc;
        exp_t e;
        stalls = 0;
        cyc    = 0;
        @(negedge clk);
        bus.ex_valid     = 1'b1;
        bus.ex_is_muldiv = 1'b1;
        bus.ex_funct3    = f3;
        bus.ex_rs1       = a;
        bus.ex_rs2       = b;
        e.name = name;
        e.val  = exp_r;
        exp_q.push_back(e);
        #1;
        while (bus.md_valid !== 1'b1 && cyc < 100) begin
            if (bus.md_stall === 1'b1) stalls++;
            @(negedge clk);
            bus.ex_valid = 1'b0;
            #1;
            cyc++;
        end
        if (cyc >= 100) check({name, "_timeout"}, 32'(bus.md_valid), 32'd1);
        check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({name, "_done_stall"}, 32'(bus.md_stall), 32'd0);
    endtask

    initial begin
        int seen;
        bus.ex_valid     = 1'b0;
        bus.ex_is_muldiv = 1'b0;
        bus.ex_funct3    = 3'b000;
        bus.ex_rs1       = '0;
        bus.ex_rs2       = '0;
        bus.ex_flush     = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("reset_stall", 32'(bus.md_stall), 32'd0);
        check("reset_valid", 32'(bus.md_valid), 32'd0);
        check("reset_result", bus.md_result, 32'd0);
        rst = 1'b0;

        do_op("MUL_7_m3",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("MULH_min_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        do_op("MULHSU_m1_max",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("MULHU_max_max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("MULH_m1_m1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        do_op("DIVU_100_0",     3'b101, 32'd100,        32'd0,         32'hFFFF_FFFF, 1);
        do_op("DIV_5_0",        3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        do_op("REMU_1234_0",    3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 1);
        do_op("REM_min_m1",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        do_op("DIV_min_m1",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("DIV_m7_2",       3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        do_op("REM_m7_2",       3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        do_op("DIV_20_m6",      3'b100, 32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 33);
        do_op("REM_20_m6",      3'b110, 32'd20,         32'hFFFF_FFFA, 32'h0000_0002, 33);
        do_op("REM_m20_6",      3'b110, 32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, 33);
        do_op("DIVU_max_1",     3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33);

        // Flush during the tenth BUSY cycle of DIV 1000/3: no result may appear.
        @(negedge clk);
        bus.ex_valid  = 1'b1;
        bus.ex_funct3 = 3'b100;
        bus.ex_rs1    = 32'd1000;
        bus.ex_rs2    = 32'd3;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.ex_flush = 1'b1;
        @(negedge clk);
        bus.ex_flush = 1'b0;
        #1;
        check("flush_stall", 32'(bus.md_stall), 32'd0);
        check("flush_valid", 32'(bus.md_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.md_valid === 1'b1) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        // Back-to-back: REMU is accepted in the cycle right after DIVU's DONE.
        do_op("DIVU_10_3", 3'b101, 32'd10, 32'd3, 32'd3, 33);
        do_op("REMU_10_3", 3'b111, 32'd10, 32'd3, 32'd1, 33);

        // Synchronous reset in the middle of a multiply.
        @(negedge clk);
        bus.ex_valid  = 1'b1;
        bus.ex_funct3 = 3'b000;
        bus.ex_rs1    = 32'd5;
        bus.ex_rs2    = 32'd5;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stall", 32'(bus.md_stall), 32'd0);
        check("midrst_valid", 32'(bus.md_valid), 32'd0);
        check("midrst_result", bus.md_result, 32'd0);
        rst = 1'b0;
        do_op("MUL_2_3_after_rst", 3'b000, 32'd2, 32'd3, 32'd6, 33);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
